// File: rtl/jls_input_receiver_pkg.sv
// Shared widths, FSM encoding and buffered-group layout for the raw-image feed receiver.
package jls_input_receiver_pkg;

    localparam int unsigned W_WIDTH = 11;
    localparam int unsigned H_WIDTH = 16;
    localparam int unsigned GROUP_W = 40;
    localparam int unsigned FLAG_W  = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHdr   = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } rx_state_e;

    // pix holds {x4,x3,x2,x1,x0}, x0 in the low byte.
    typedef struct packed {
        logic [GROUP_W-1:0] pix;
        logic               sol;
        logic               eol;
        logic               eof;
    } rx_group_t;

endpackage

// File: rtl/jls_input_receiver_if.sv
// Feed-side and encoder-side signals of the receiver; slave = receiver, master = environment.
interface jls_input_receiver_if;
    import jls_input_receiver_pkg::*;

    logic               i_sof;
    logic [W_WIDTH-1:0] i_w;
    logic [H_WIDTH-1:0] i_h;
    logic               i_rdy;
    logic               i_e;
    logic [7:0]         i_x0, i_x1, i_x2, i_x3, i_x4;
    logic [W_WIDTH-1:0] o_w;
    logic [H_WIDTH-1:0] o_h;
    logic               o_sof;
    logic               o_e;
    logic               o_rdy;
    logic [7:0]         o_x0, o_x1, o_x2, o_x3, o_x4;
    logic               o_sol, o_eol, o_eof;
    logic               o_done;
    logic               o_err_sof;

    modport slave (
        input  i_sof, i_w, i_h, i_e, i_x0, i_x1, i_x2, i_x3, i_x4, o_rdy,
        output i_rdy, o_w, o_h, o_sof, o_e, o_x0, o_x1, o_x2, o_x3, o_x4,
        output o_sol, o_eol, o_eof, o_done, o_err_sof
    );

    modport master (
        output i_sof, i_w, i_h, i_e, i_x0, i_x1, i_x2, i_x3, i_x4, o_rdy,
        input  i_rdy, o_w, o_h, o_sof, o_e, o_x0, o_x1, o_x2, o_x3, o_x4,
        input  o_sol, o_eol, o_eof, o_done, o_err_sof
    );

endinterface

// File: rtl/jls_rx_fifo.sv
// Synchronous fall-through FIFO with flush; head entry is visible combinationally on rdata.
module jls_rx_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // Push while full is only honoured together with a pop.
    assign do_push = push && ((count_q != AW'(0) + (AW+1)'(DEPTH)) || pop);
    assign do_pop  = pop && (count_q != '0);
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    // Pointer and occupancy update; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/jls_input_receiver.sv
// Raw-image feed receiver: latches frame size, accepts 5-pixel groups, tags sol/eol/eof
// and buffers them for the encoder core. Define JLS_RX_STATS_EN to add o_cycles/o_groups.
module jls_input_receiver
    import jls_input_receiver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    jls_input_receiver_if.slave bus
`ifdef JLS_RX_STATS_EN
    ,
    output logic [31:0]         o_cycles,
    output logic [31:0]         o_groups
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_e          state_q, state_d;
    logic [W_WIDTH-1:0] w_q, col_q;
    logic [H_WIDTH-1:0] h_q, row_q;
    logic               i_rdy_q, i_rdy_d;
    logic               sof_q, sof_d;
    logic               err_q, err_d;
    logic               accept, pop, flush, done, in_frame, eol, eof_grp;
    logic [CW-1:0]      count, next_count;
    rx_group_t          wr_grp, rd_grp;

    // Control decodes; an i_sof during a frame aborts and beats any concurrent group.
    assign in_frame = (state_q == StRun) || (state_q == StDrain);
    assign accept   = (state_q == StRun) && bus.i_e && i_rdy_q && !bus.i_sof;
    assign flush    = in_frame && bus.i_sof;
    assign pop      = (count != '0) && bus.o_rdy;
    assign done     = (state_q == StDrain) && !bus.i_sof && pop && rd_grp.eof;
    assign sof_d    = (state_q == StHdr) && !bus.i_sof;
    assign eol      = (col_q == w_q);
    assign eof_grp  = eol && (row_q == h_q);

    assign next_count = flush ? '0 :
                        count + CW'(accept) - CW'(pop);

    assign wr_grp = '{pix: {bus.i_x4, bus.i_x3, bus.i_x2, bus.i_x1, bus.i_x0},
                      sol: (col_q == '0), eol: eol, eof: eof_grp};

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.i_sof) state_d = StHdr;
            StHdr:   if (!bus.i_sof) state_d = StRun;
            StRun: begin
                if (bus.i_sof)               state_d = StHdr;
                else if (accept && eof_grp)  state_d = StDrain;
            end
            StDrain: begin
                if (bus.i_sof) state_d = StHdr;
                else if (done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: next i_rdy and sticky abort flag.
    always_comb begin
        i_rdy_d = (state_d == StRun) && (next_count < CW'(FIFO_DEPTH));
        err_d   = err_q;
        if (sof_d) err_d = 1'b0;
        if (flush) err_d = 1'b1;
    end

    // Registered handshake/status outputs, size latches and column/row position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_rdy_q <= 1'b0;
            sof_q   <= 1'b0;
            err_q   <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            i_rdy_q <= i_rdy_d;
            sof_q   <= sof_d;
            err_q   <= err_d;
            if (bus.i_sof) begin
                w_q <= bus.i_w;
                h_q <= bus.i_h;
            end
            if (sof_d) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept) begin
                if (eol) begin
                    col_q <= '0;
                    row_q <= row_q + H_WIDTH'(1);
                end else begin
                    col_q <= col_q + W_WIDTH'(1);
                end
            end
        end
    end

    jls_rx_fifo #(
        .WIDTH ($bits(rx_group_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (accept),
        .pop   (pop),
        .wdata (wr_grp),
        .rdata (rd_grp),
        .count (count)
    );

    assign bus.i_rdy     = i_rdy_q;
    assign bus.o_w       = w_q;
    assign bus.o_h       = h_q;
    assign bus.o_sof     = sof_q;
    assign bus.o_e       = (count != '0);
    assign bus.o_x0      = rd_grp.pix[7:0];
    assign bus.o_x1      = rd_grp.pix[15:8];
    assign bus.o_x2      = rd_grp.pix[23:16];
    assign bus.o_x3      = rd_grp.pix[31:24];
    assign bus.o_x4      = rd_grp.pix[39:32];
    assign bus.o_sol     = rd_grp.sol;
    assign bus.o_eol     = rd_grp.eol;
    assign bus.o_eof     = rd_grp.eof;
    assign bus.o_done    = done;
    assign bus.o_err_sof = err_q;

`ifdef JLS_RX_STATS_EN
    logic [31:0] cycles_q, groups_q;

    // Frame throughput counters; cleared on RUN entry, frozen from the done cycle on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycles_q <= '0;
            groups_q <= '0;
        end else if (sof_d) begin
            cycles_q <= '0;
            groups_q <= '0;
        end else if (in_frame && !done) begin
            cycles_q <= cycles_q + 32'd1;
            if (accept) groups_q <= groups_q + 32'd1;
        end
    end

    assign o_cycles = cycles_q;
    assign o_groups = groups_q;
`endif

endmodule
